// File: rtl/spi_port_arbiter.sv
// Round-robin arbiter sharing one 16-bit SPI master between two requesters.
// Buffers one command per requester, steers chip selects and aborts hung transactions.
module spi_port_arbiter #(
  parameter int unsigned TO_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_wrt,
  input  logic [15:0] req0_cmd,
  output logic        req0_done,
  output logic [15:0] req0_rd_data,
  output logic        req0_busy,
  input  logic        req1_wrt,
  input  logic [15:0] req1_cmd,
  output logic        req1_done,
  output logic [15:0] req1_rd_data,
  output logic        req1_busy,
  output logic        mst_wrt,
  output logic [15:0] mst_cmd,
  input  logic        mst_done,
  input  logic [15:0] mst_rd_data,
  input  logic        mst_SS_n,
  output logic        SS_n0,
  output logic        SS_n1,
  output logic        timeout
);

  localparam int unsigned DW = 16;
  // Watchdog fires on the WAIT_DONE cycle whose increment lands on all ones.
  localparam logic [TO_W-1:0] WD_PRE_TC = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sel, w_sel_nxt;
  logic            r_last;
  logic            r_pend0, r_pend1;
  logic [DW-1:0]   r_hold0, r_hold1;
  logic [DW-1:0]   r_rd0, r_rd1;
  logic            r_done0, r_done1;
  logic            r_timeout;
  logic            r_mst_wrt;
  logic [TO_W-1:0] r_wd;
  logic            w_fin, w_to, w_wd_tc;

  assign w_wd_tc = (r_wd == WD_PRE_TC);

  // Next-state, grant and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_fin       = 1'b0;
    w_to        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend0 || r_pend1) begin
          w_state_nxt = ST_ISSUE;
          if (r_pend0 && r_pend1) w_sel_nxt = ~r_last;
          else                    w_sel_nxt = r_pend1;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mst_done) begin
          w_fin       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_wd_tc) begin
          w_fin       = 1'b1;
          w_to        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sel     <= 1'b0;
      r_last    <= 1'b1;
      r_pend0   <= 1'b0;
      r_pend1   <= 1'b0;
      r_hold0   <= '0;
      r_hold1   <= '0;
      r_rd0     <= '0;
      r_rd1     <= '0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_timeout <= 1'b0;
      r_mst_wrt <= 1'b0;
      r_wd      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_mst_wrt <= (w_state_nxt == ST_ISSUE);
      r_done0   <= w_fin && !r_sel;
      r_done1   <= w_fin && r_sel;
      r_timeout <= w_to;

      if (r_state == ST_ISSUE)     r_wd <= '0;
      else if (r_state == ST_WAIT) r_wd <= r_wd + TO_W'(1);

      if (w_fin) begin
        r_last <= r_sel;
        if (!r_sel) r_rd0 <= w_to ? 16'hFFFF : mst_rd_data;
        else        r_rd1 <= w_to ? 16'hFFFF : mst_rd_data;
      end

      // A strobe while a command is already held is dropped.
      if (w_fin && !r_sel) begin
        r_pend0 <= 1'b0;
      end else if (req0_wrt && !r_pend0) begin
        r_pend0 <= 1'b1;
        r_hold0 <= req0_cmd;
      end

      if (w_fin && r_sel) begin
        r_pend1 <= 1'b0;
      end else if (req1_wrt && !r_pend1) begin
        r_pend1 <= 1'b1;
        r_hold1 <= req1_cmd;
      end
    end
  end

  assign req0_done    = r_done0;
  assign req1_done    = r_done1;
  assign req0_rd_data = r_rd0;
  assign req1_rd_data = r_rd1;
  assign req0_busy    = r_pend0;
  assign req1_busy    = r_pend1;
  assign timeout      = r_timeout;
  assign mst_wrt      = r_mst_wrt;
  assign mst_cmd      = (r_state == ST_IDLE) ? 16'h0000 : (r_sel ? r_hold1 : r_hold0);

  // Non-selected slave never sees an active select.
  assign SS_n0 = mst_SS_n | (r_state == ST_IDLE) | r_sel;
  assign SS_n1 = mst_SS_n | (r_state == ST_IDLE) | ~r_sel;

endmodule
